uart_cmd_rcv: RTL and testbench
===============================

# uart_cmd_rcv

Copter-side endpoint of the wireless command link. Deserializes 3-byte command frames (opcode, data high, data low) arriving on RX into `cmd`/`data` with a `cmd_rdy` flag for the command handler, and serializes 8-bit responses (e.g. 0xA5 ack, battery level) back out on TX. Sits between the QuadCopter RX/TX pins and the command-processing FSM; it is the peer of the host-side command master.

## Interface
- `BAUD_DIV`, 2604: clk cycles per bit (19200 baud at 50 MHz).
- `TIMEOUT_CYC`, 20'd1_000_000: max idle clk cycles between bytes of one frame (used only with `CMD_TIMEOUT_EN`).

- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `RX` in 1: serial input, idle high; asynchronous to `clk`.
- `TX` out 1: serial output, idle high.
- `cmd` out 8: opcode of last complete frame.
- `data` out 16: {byte2, byte3} of last complete frame.
- `cmd_rdy` out 1: complete frame available.
- `clr_cmd_rdy` in 1: knocks down `cmd_rdy`.
- `resp` in 8: response byte to send.
- `snd_resp` in 1: one-cycle strobe; launch `resp`.
- `resp_sent` out 1: one-cycle pulse when the stop bit of the response completes.
- `tx_busy` out 1: transmitter active.

## Operation
- RX path: `RX` passes through two flops (reset to 1) before use. Falling edge of the synchronized line while idle starts a byte. Bit counter samples at BAUD_DIV/2 into the start bit, then every BAUD_DIV: start, 8 data bits LSB first, stop.
  - Start bit sampled high: false start; return to idle.
  - Stop bit sampled low: framing error; byte discarded; frame FSM returns to WAIT_CMD.
- Frame FSM states: WAIT_CMD → WAIT_HI → WAIT_LO → WAIT_CMD.
  - Each valid received byte advances one state, storing into the cmd, high, or low holding register.
  - On the third byte, `cmd`/`data` update and `cmd_rdy` sets.
  - `cmd`/`data` change only on frame completion; partial frames never disturb them.
- `cmd_rdy` clears on `clr_cmd_rdy`, or when the start bit of the next frame's opcode byte is detected. If completion and `clr_cmd_rdy` occur in the same cycle, set wins.
- TX path: states IDLE → TRANSMIT.
  - `snd_resp` in IDLE latches `resp` into a 10-bit shift register {1, resp, 0}. TX shifts LSB first, one bit per BAUD_DIV cycles.
  - After 10 bits: `resp_sent` pulses and the FSM returns to IDLE.
  - `snd_resp` while `tx_busy` is ignored; the latched byte is not corrupted.
- RX and TX are fully independent; simultaneous receive and transmit are required.
- `rst` mid-frame or mid-byte: all FSMs return to idle and partial data is discarded. TX goes high on the next edge.

## Timing
- Reset values: `TX`=1, `cmd`=0, `data`=0, `cmd_rdy`=0, `resp_sent`=0, `tx_busy`=0.
- `cmd_rdy` rises 1 clk after the third byte's stop-bit sample (mid-stop-bit). `cmd`/`data` are valid the same cycle.
- RX latency: 2 sync cycles + sample offset; a frame completes ≈ 29.5·BAUD_DIV + 3 clks after the first start-bit edge.
- TX: `TX` drops to start bit 1 clk after `snd_resp`. `tx_busy` rises the same edge. Each bit is held exactly BAUD_DIV clks. `resp_sent` pulses 10·BAUD_DIV+1 clks after `snd_resp`, in the same cycle `tx_busy` falls.
- A new `snd_resp` is accepted the cycle after `resp_sent`.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - An inter-byte counter runs in WAIT_HI/WAIT_LO and resets on each start bit.
  - When it reaches `TIMEOUT_CYC`, the frame FSM returns to WAIT_CMD and the partial frame is dropped. `cmd_rdy`/`cmd`/`data` are unaffected.
- Not defined: no counter; the frame FSM waits indefinitely for the remaining bytes.

## Test plan
- Send 0x01, 0x00, 0x00 → `cmd_rdy`=1, `cmd`=0x01, `data`=0x0000. `clr_cmd_rdy` pulse → `cmd_rdy`=0 next cycle.
- Send 0x02, 0x12, 0x34, then 0x05, 0xAB, 0xCD back to back → first `cmd`=0x02 `data`=0x1234. `cmd_rdy` drops at the fourth start bit. Then `cmd`=0x05 `data`=0xABCD.
- `resp`=0xC0, `snd_resp` pulse → TX bit sequence 0,0,0,0,0,0,0,1,1,1 each BAUD_DIV wide; `resp_sent` pulse at 10·BAUD_DIV+1. A second `snd_resp` mid-byte is ignored.
- Opcode byte with stop bit forced low, then valid 0x03,0x00,0x10 → only one frame: `cmd`=0x03, `data`=0x0010.
- Under `UART_CMD_TIMEOUT_EN` with `TIMEOUT_CYC`=5000: send 0x04, 0x11, idle 6000 clks, then 0x06,0x00,0x00 → `cmd`=0x06, `data`=0x0000. Without the macro → `cmd`=0x04, `data`=0x1106.
- Assert `rst` after the second byte of a frame, then send a full 0x08,0x00,0x00 → outputs reset to 0 and `TX`=1 after reset. Frame decodes as `cmd`=0x08, `data`=0x0000.

Source files
------------

// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: copter-side UART endpoint of the wireless command link.
// Receives 3-byte frames (opcode, data high, data low) on RX and presents them
// as cmd/data with a cmd_rdy flag; serializes 8-bit responses out on TX.
// Optional feature macro: UART_CMD_TIMEOUT_EN -- when defined, a partial frame
// is dropped if the gap between its bytes reaches TIMEOUT_CYC clocks.
`timescale 1ns/1ps

module uart_cmd_rcv #(
    parameter int          BAUD_DIV    = 2604,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        snd_resp,
    output logic        resp_sent,
    output logic        tx_busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_BUSY = 1'b1;

    localparam logic [1:0] WAIT_CMD = 2'd0;
    localparam logic [1:0] WAIT_HI  = 2'd1;
    localparam logic [1:0] WAIT_LO  = 2'd2;

    localparam logic [0:0] TX_IDLE     = 1'b0;
    localparam logic [0:0] TX_TRANSMIT = 1'b1;

    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    logic [0:0]      rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_baud_q, rx_baud_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            start_det, byte_vld, frame_err;

    logic [1:0]      frm_state_q, frm_state_d;
    logic [7:0]      cmd_hold_q, cmd_hold_d;
    logic [7:0]      hi_hold_q, hi_hold_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [15:0]     data_q, data_d;
    logic            cmd_rdy_q, cmd_rdy_d;

    logic [0:0]      tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_baud_q, tx_baud_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [8:0]      tx_sh_q, tx_sh_d;
    logic            tx_q, tx_d;
    logic            resp_sent_q, resp_sent_d;

    // Two-flop synchronizer for RX plus a third stage used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
        end else begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= {RX, rx_s1_q, rx_s2_q};
        end
    end

    // Byte receiver: find the start edge, then sample mid-bit start, 8 data bits, stop.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        start_det  = 1'b0;
        byte_vld   = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q && rx_s3_q) begin
                    start_det  = 1'b1;
                    rx_state_d = RX_BUSY;
                    rx_baud_d  = HALF_LAST;
                    rx_bit_d   = 4'd0;
                end
            end
            default: begin
                if (rx_baud_q != '0) begin
                    rx_baud_d = rx_baud_q - 1'b1;
                end else begin
                    rx_baud_d = BAUD_LAST;
                    if (rx_bit_q == 4'd0) begin
                        if (rx_s2_q) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_bit_d = 4'd1;
                        end
                    end else if (rx_bit_q == 4'd9) begin
                        rx_state_d = RX_IDLE;
                        if (rx_s2_q) begin
                            byte_vld = 1'b1;
                        end else begin
                            frame_err = 1'b1;
                        end
                    end else begin
                        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
        endcase
    end

`ifdef UART_CMD_TIMEOUT_EN
    logic [19:0] tmo_cnt_q, tmo_cnt_d;

    // Inter-byte gap counter: idle while waiting for an opcode, restarts at every start bit.
    always_comb begin
        if (frm_state_q == WAIT_CMD || start_det) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TIMEOUT_CYC) begin
            tmo_cnt_d = tmo_cnt_q + 20'd1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Gap counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    // TIMEOUT_CYC only matters with the timeout feature; kept so instantiations match both builds.
    if (TIMEOUT_CYC == 20'd0) begin : g_timeout_unused
    end
`endif

    // Frame assembler: collect opcode/high/low, publish cmd/data only on a complete frame.
    always_comb begin
        frm_state_d = frm_state_q;
        cmd_hold_d  = cmd_hold_q;
        hi_hold_d   = hi_hold_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        cmd_rdy_d   = cmd_rdy_q;
        if (clr_cmd_rdy || (start_det && frm_state_q == WAIT_CMD)) begin
            cmd_rdy_d = 1'b0;
        end
        if (frame_err) begin
            frm_state_d = WAIT_CMD;
        end else if (byte_vld) begin
            case (frm_state_q)
                WAIT_CMD: begin
                    cmd_hold_d  = rx_sh_q;
                    frm_state_d = WAIT_HI;
                end
                WAIT_HI: begin
                    hi_hold_d   = rx_sh_q;
                    frm_state_d = WAIT_LO;
                end
                WAIT_LO: begin
                    cmd_d       = cmd_hold_q;
                    data_d      = {hi_hold_q, rx_sh_q};
                    cmd_rdy_d   = 1'b1;
                    frm_state_d = WAIT_CMD;
                end
                default: frm_state_d = WAIT_CMD;
            endcase
        end
`ifdef UART_CMD_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT_CYC && frm_state_q != WAIT_CMD) begin
            frm_state_d = WAIT_CMD;
        end
`endif
    end

    // Transmitter: latch {stop, resp} and shift one bit every BAUD_DIV clocks after the start bit.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        tx_sh_d     = tx_sh_q;
        tx_d        = tx_q;
        resp_sent_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (snd_resp) begin
                    tx_state_d = TX_TRANSMIT;
                    tx_d       = 1'b0;
                    tx_sh_d    = {1'b1, resp};
                    tx_bit_d   = 4'd0;
                    tx_baud_d  = BAUD_LAST;
                end
            end
            default: begin
                if (tx_baud_q != '0) begin
                    tx_baud_d = tx_baud_q - 1'b1;
                end else if (tx_bit_q == 4'd9) begin
                    tx_state_d  = TX_IDLE;
                    tx_d        = 1'b1;
                    resp_sent_d = 1'b1;
                end else begin
                    tx_d      = tx_sh_q[0];
                    tx_sh_d   = {1'b1, tx_sh_q[8:1]};
                    tx_bit_d  = tx_bit_q + 4'd1;
                    tx_baud_d = BAUD_LAST;
                end
            end
        endcase
    end

    // State registers for receiver, frame assembler and transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_baud_q   <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            frm_state_q <= WAIT_CMD;
            cmd_hold_q  <= '0;
            hi_hold_q   <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_baud_q   <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '1;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            frm_state_q <= frm_state_d;
            cmd_hold_q  <= cmd_hold_d;
            hi_hold_q   <= hi_hold_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_state_q  <= tx_state_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign data      = data_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;
    assign tx_busy   = (tx_state_q == TX_TRANSMIT);

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb_uart_cmd_rcv: randomized bench for uart_cmd_rcv with a frame-level
// reference model and scoreboard queues drained by independent RX/TX monitors.
`timescale 1ns/1ps

module tb_uart_cmd_rcv;

    localparam int          B   = 16;
    localparam logic [19:0] TMO = 20'd5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        snd_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        resp_sent;
    logic        tx_busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    logic [7:0]  partial[$];
    logic [7:0]  exp_cmd_q[$];
    logic [15:0] exp_data_q[$];
    logic [7:0]  model_cmd = 8'h00;
    logic [15:0] model_data = 16'h0000;
    logic [7:0]  tx_exp_q[$];
    int          tx_issue_q[$];
    int          tx_free = 0;
    logic        rdy_prev = 1'b0;

    uart_cmd_rcv #(.BAUD_DIV(B), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .RX(RX),
        .TX(TX),
        .cmd(cmd),
        .data(data),
        .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp),
        .snd_resp(snd_resp),
        .resp_sent(resp_sent),
        .tx_busy(tx_busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency bookkeeping.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idleLine(input int n);
        RX = 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
        if (n >= int'(TMO)) partial.delete();
`endif
        waitCycles(n);
    endtask

    // Sends one serial byte; the model decides up front what the frame layer will report.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_stop, input bit chk_drop);
        logic [9:0] bits;
        if (bad_stop) begin
            partial.delete();
        end else begin
            partial.push_back(b);
            if (partial.size() == 3) begin
                model_cmd  = partial[0];
                model_data = {partial[1], partial[2]};
                exp_cmd_q.push_back(model_cmd);
                exp_data_q.push_back(model_data);
                partial.delete();
            end
        end
        bits = {~bad_stop, b, 1'b0};
        if (chk_drop) checkOutput("rdy_before_opcode", cmd_rdy, 1);
        for (int k = 0; k < 10; k++) begin
            RX = bits[k];
            if (chk_drop && k == 0) begin
                waitCycles(6);
                checkOutput("rdy_cleared_by_start", cmd_rdy, 0);
                waitCycles(B - 6);
            end else begin
                waitCycles(B);
            end
        end
        RX = 1'b1;
        if (bad_stop) waitCycles(B);
        checkOutput("cmd_hold", cmd, model_cmd);
        checkOutput("data_hold", data, model_data);
    endtask

    task automatic txIssue(input logic [7:0] v);
        resp = v;
        snd_resp = 1'b1;
        if (cyc >= tx_free) begin
            tx_exp_q.push_back(v);
            tx_issue_q.push_back(cyc);
            tx_free = cyc + 10 * B + 1;
        end
        waitCycles(1);
        snd_resp = 1'b0;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_TX", TX, 1);
        checkOutput("rst_cmd", cmd, 0);
        checkOutput("rst_data", data, 0);
        checkOutput("rst_cmd_rdy", cmd_rdy, 0);
        checkOutput("rst_resp_sent", resp_sent, 0);
        checkOutput("rst_tx_busy", tx_busy, 0);
    endtask

    task automatic checkTxByte();
        int t0;
        int iss;
        logic [7:0] e;
        logic [9:0] fr;
        t0 = cyc;
        if (tx_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL tx_unexpected: got a start bit at cycle %0d, expected idle line", t0);
            for (int i = 0; i < 11 * B && TX !== 1'b1; i++) @(negedge clk);
            return;
        end
        e   = tx_exp_q.pop_front();
        iss = tx_issue_q.pop_front();
        fr  = {1'b1, e, 1'b0};
        checkOutput("tx_start_latency", t0, iss + 1);
        checkOutput("tx_busy_rise", tx_busy, 1);
        for (int o = 0; o < 10 * B; o++) begin
            if (o > 0) @(negedge clk);
            if (o % B == 0 || o % B == B - 1) checkOutput("tx_bit", TX, fr[o / B]);
            if (o == 10 * B - 1) checkOutput("resp_sent_early", resp_sent, 0);
        end
        @(negedge clk);
        checkOutput("resp_sent_pulse", resp_sent, 1);
        checkOutput("tx_busy_fall", tx_busy, 0);
        checkOutput("tx_idle_high", TX, 1);
    endtask

    // Frame monitor: each rising cmd_rdy must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst) begin
            rdy_prev = 1'b0;
        end else begin
            if (cmd_rdy && !rdy_prev) begin
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL frame_unexpected: got cmd=0x%0h data=0x%0h, expected no frame", cmd, data);
                end else begin
                    checkOutput("frame_cmd", cmd, exp_cmd_q.pop_front());
                    checkOutput("frame_data", data, exp_data_q.pop_front());
                end
            end
            rdy_prev = cmd_rdy;
        end
    end

    // Transmit monitor: every start bit on TX is checked against the oldest accepted response.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && TX === 1'b0) checkTxByte();
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        repeat (95000) @(posedge clk);
        errors++;
        $display("[TB] FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed scenarios, then concurrent random RX/TX traffic.
    initial begin
        waitCycles(4);
        checkResetValues();
        rst = 1'b0;
        waitCycles(4);

        $display("[TB] single frame and clear");
        applyStimulus(8'h01, 0, 0);
        applyStimulus(8'h00, 0, 0);
        applyStimulus(8'h00, 0, 0);
        checkOutput("rdy_after_frame", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        waitCycles(1);
        clr_cmd_rdy = 1'b0;
        checkOutput("rdy_after_clear", cmd_rdy, 0);
        idleLine(20);

        $display("[TB] back-to-back frames");
        applyStimulus(8'h02, 0, 0);
        applyStimulus(8'h12, 0, 0);
        applyStimulus(8'h34, 0, 0);
        applyStimulus(8'h05, 0, 1);
        applyStimulus(8'hAB, 0, 0);
        applyStimulus(8'hCD, 0, 0);
        idleLine(20);

        $display("[TB] response transmit");
        txIssue(8'hC0);
        waitCycles(5 * B);
        txIssue(8'hFF);
        while (cyc < tx_free) waitCycles(1);
        txIssue(8'h3C);
        waitCycles(11 * B);

        $display("[TB] framing error");
        applyStimulus(8'h5A, 1, 0);
        applyStimulus(8'h03, 0, 0);
        applyStimulus(8'h00, 0, 0);
        applyStimulus(8'h10, 0, 0);
        idleLine(20);

        $display("[TB] inter-byte gap");
        applyStimulus(8'h04, 0, 0);
        applyStimulus(8'h11, 0, 0);
        idleLine(6000);
        applyStimulus(8'h06, 0, 0);
        applyStimulus(8'h00, 0, 0);
        applyStimulus(8'h00, 0, 0);
        idleLine(20);

        $display("[TB] reset mid-frame");
        while (partial.size() < 2) applyStimulus(8'($urandom), 0, 0);
        rst = 1'b1;
        partial.delete();
        model_cmd  = 8'h00;
        model_data = 16'h0000;
        waitCycles(2);
        checkResetValues();
        rst = 1'b0;
        waitCycles(3);
        applyStimulus(8'h08, 0, 0);
        applyStimulus(8'h00, 0, 0);
        applyStimulus(8'h00, 0, 0);
        idleLine(20);

        $display("[TB] random traffic");
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    for (int i = 0; i < 3; i++) begin
                        bit bad;
                        bit hold;
                        bad  = ($urandom_range(0, 15) == 0);
                        hold = (i == 2) && ($urandom_range(0, 3) == 0);
                        if (hold) clr_cmd_rdy = 1'b1;
                        applyStimulus(8'($urandom), bad, 0);
                        clr_cmd_rdy = 1'b0;
                        idleLine($urandom_range(0, 40));
                        if ($urandom_range(0, 5) == 0) begin
                            clr_cmd_rdy = 1'b1;
                            waitCycles(1);
                            clr_cmd_rdy = 1'b0;
                        end
                    end
                end
            end
            begin
                for (int n = 0; n < 14; n++) begin
                    int target;
                    target = tx_free + (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60)));
                    while (cyc < target) waitCycles(1);
                    txIssue(8'($urandom));
                    if ($urandom_range(0, 2) == 0) begin
                        waitCycles($urandom_range(0, 10 * B - 1));
                        txIssue(8'($urandom));
                    end
                end
            end
        join
        waitCycles(12 * B);

        checkOutput("frames_pending", exp_cmd_q.size(), 0);
        checkOutput("tx_pending", tx_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
